// File: rtl/ir_pixel_packer_if.sv
// Pixel-stream and FIFO write-side signals shared by the packer and its environment.
interface ir_pixel_packer_if #(
   parameter int unsigned P_PIXEL_WIDTH = 16,
   parameter int unsigned P_PACK_WIDTH  = 32
);
   logic                     s_pix_valid;
   logic                     s_pix_ready;
   logic [P_PIXEL_WIDTH-1:0] s_pix_data;
   logic                     s_pix_eol;
   logic                     fifo_full;
   logic                     fifo_wr_rst_busy;
   logic                     fifo_wr_en;
   logic [P_PACK_WIDTH-1:0]  fifo_din;

   // Environment side: sensor front end plus FIFO status
   modport master (
      output s_pix_valid, s_pix_data, s_pix_eol, fifo_full, fifo_wr_rst_busy,
      input  s_pix_ready, fifo_wr_en, fifo_din
   );

   // Packer side
   modport slave (
      input  s_pix_valid, s_pix_data, s_pix_eol, fifo_full, fifo_wr_rst_busy,
      output s_pix_ready, fifo_wr_en, fifo_din
   );
endinterface

// File: rtl/ir_pixel_packer.sv
// Packs N = P_PACK_WIDTH/P_PIXEL_WIDTH sensor pixels into one async-FIFO write word,
// padding short words at end of line and counting completed lines.
module ir_pixel_packer #(
   parameter int unsigned                P_PIXEL_WIDTH    = 16,
   parameter int unsigned                P_PACK_WIDTH     = 32,
   parameter logic [P_PIXEL_WIDTH-1:0]   P_PAD_VALUE      = '0,
   parameter int unsigned                P_LINE_CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ir_pixel_packer_if.slave            bus,
   output logic                        line_done,
   output logic [P_LINE_CNT_WIDTH-1:0] line_cnt
);

   localparam int unsigned N         = P_PACK_WIDTH / P_PIXEL_WIDTH;
   localparam int unsigned SLOT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N - 1);

   typedef enum logic {
      ST_STARTUP = 1'b0,
      ST_RUN     = 1'b1
   } state_e;

   state_e                      state_q, state_d;
   logic [SLOT_W-1:0]           slot_q, slot_d;
   logic [P_PACK_WIDTH-1:0]     part_q, part_d;
   logic                        word_vld_q, word_vld_d;
   logic                        word_eol_q, word_eol_d;
   logic [P_PACK_WIDTH-1:0]     din_q, din_d;
   logic                        line_done_q, line_done_d;
   logic [P_LINE_CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;

   logic                        wr_en_c;
   logic                        ready_c;
   logic                        accept_c;
   logic [P_PACK_WIDTH-1:0]     asm_c;

   // Handshakes are combinational on registered state so a held word and a new pixel can move together
   always_comb begin
      wr_en_c  = word_vld_q & ~bus.fifo_full & ~bus.fifo_wr_rst_busy & (state_q == ST_RUN);
      ready_c  = (state_q == ST_RUN) & (~word_vld_q | wr_en_c);
      accept_c = bus.s_pix_valid & ready_c;
   end

   // Word as it would look with the current pixel in lane slot: earlier lanes from the partial, later lanes padded
   always_comb begin
      asm_c = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (k < 32'(slot_q)) begin
            asm_c[k*P_PIXEL_WIDTH +: P_PIXEL_WIDTH] = part_q[k*P_PIXEL_WIDTH +: P_PIXEL_WIDTH];
         end else if (k == 32'(slot_q)) begin
            asm_c[k*P_PIXEL_WIDTH +: P_PIXEL_WIDTH] = bus.s_pix_data;
         end else begin
            asm_c[k*P_PIXEL_WIDTH +: P_PIXEL_WIDTH] = P_PAD_VALUE;
         end
      end
   end

   // Next-state: startup gating, packing, word hand-off and line accounting
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      part_d      = part_q;
      word_vld_d  = word_vld_q;
      word_eol_d  = word_eol_q;
      din_d       = din_q;
      line_done_d = 1'b0;
      line_cnt_d  = line_cnt_q;

      case (state_q)
         ST_STARTUP: begin
            slot_d     = '0;
            word_vld_d = 1'b0;
            word_eol_d = 1'b0;
            if (!bus.fifo_wr_rst_busy) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.fifo_wr_rst_busy) begin
               // FIFO is being reset: anything in flight is lost with it
               state_d    = ST_STARTUP;
               slot_d     = '0;
               word_vld_d = 1'b0;
               word_eol_d = 1'b0;
            end else begin
               if (wr_en_c) begin
                  word_vld_d = 1'b0;
                  if (word_eol_q) begin
                     line_done_d = 1'b1;
                     line_cnt_d  = line_cnt_q + P_LINE_CNT_WIDTH'(1);
                  end
               end
               if (accept_c) begin
                  if ((slot_q == LAST_SLOT) || bus.s_pix_eol) begin
                     din_d      = asm_c;
                     word_vld_d = 1'b1;
                     word_eol_d = bus.s_pix_eol;
                     slot_d     = '0;
                  end else begin
                     part_d = asm_c;
                     slot_d = slot_q + SLOT_W'(1);
                  end
               end
            end
         end
         default: state_d = ST_STARTUP;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_STARTUP;
         slot_q      <= '0;
         part_q      <= '0;
         word_vld_q  <= 1'b0;
         word_eol_q  <= 1'b0;
         din_q       <= '0;
         line_done_q <= 1'b0;
         line_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         part_q      <= part_d;
         word_vld_q  <= word_vld_d;
         word_eol_q  <= word_eol_d;
         din_q       <= din_d;
         line_done_q <= line_done_d;
         line_cnt_q  <= line_cnt_d;
      end
   end

   assign bus.s_pix_ready = ready_c;
   assign bus.fifo_wr_en  = wr_en_c;
   assign bus.fifo_din    = din_q;
   assign line_done       = line_done_q;
   assign line_cnt        = line_cnt_q;

endmodule

// File: tb/tb_ir_pixel_packer.sv
// Directed bench for ir_pixel_packer: 2-pixel packing (main DUT) and 1-pixel words (second DUT).
module tb_ir_pixel_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        line_done0, line_done1;
   logic [15:0] line_cnt0;
   logic [1:0]  line_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ir_pixel_packer_if #(.P_PIXEL_WIDTH(16), .P_PACK_WIDTH(32)) bus0 ();
   ir_pixel_packer_if #(.P_PIXEL_WIDTH(16), .P_PACK_WIDTH(16)) bus1 ();

   // Second DUT sees the same stimulus
   assign bus1.s_pix_valid      = bus0.s_pix_valid;
   assign bus1.s_pix_data       = bus0.s_pix_data;
   assign bus1.s_pix_eol        = bus0.s_pix_eol;
   assign bus1.fifo_full        = bus0.fifo_full;
   assign bus1.fifo_wr_rst_busy = bus0.fifo_wr_rst_busy;

   ir_pixel_packer #(
      .P_PIXEL_WIDTH(16), .P_PACK_WIDTH(32), .P_PAD_VALUE(16'h0000), .P_LINE_CNT_WIDTH(16)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .line_done(line_done0), .line_cnt(line_cnt0)
   );

   ir_pixel_packer #(
      .P_PIXEL_WIDTH(16), .P_PACK_WIDTH(16), .P_PAD_VALUE(16'h0000), .P_LINE_CNT_WIDTH(2)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .line_done(line_done1), .line_cnt(line_cnt1)
   );

   typedef struct {
      logic        v;
      logic [15:0] pix;
      logic        eol;
      logic        full;
      logic        busy;
      logic        e_rdy;
      logic        e_wr;
      logic [31:0] e_din;
      logic        e_ld;
      logic [15:0] e_lc;
   } vec_t;

   localparam int NV = 34;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic v, input logic [15:0] pix, input logic eol,
                               input logic full, input logic busy, input logic rdy,
                               input logic wr, input logic [31:0] din, input logic ld,
                               input logic [15:0] lc);
      vec_t r;
      r.v = v; r.pix = pix; r.eol = eol; r.full = full; r.busy = busy;
      r.e_rdy = rdy; r.e_wr = wr; r.e_din = din; r.e_ld = ld; r.e_lc = lc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] pix, input logic eol,
                        input logic full, input logic busy);
      bus0.s_pix_valid      = v;
      bus0.s_pix_data       = pix;
      bus0.s_pix_eol        = eol;
      bus0.fifo_full        = full;
      bus0.fifo_wr_rst_busy = busy;
   endtask

   logic [15:0] prev;
   logic [63:0] exp_v, act_v;

   initial begin
      //              v  pix      eol full busy rdy wr din           ld lc
      // pairs 1111/2222, 3333/4444 back-to-back
      tbl[0]  = mk(1, 16'h1111, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0);
      tbl[1]  = mk(1, 16'h2222, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0);
      tbl[2]  = mk(1, 16'h3333, 0, 0, 0, 1, 1, 32'h2222_1111, 0, 0);
      tbl[3]  = mk(1, 16'h4444, 0, 0, 0, 1, 0, 32'h2222_1111, 0, 0);
      // 3-pixel line A,B,C: odd last pixel padded
      tbl[4]  = mk(1, 16'h000A, 0, 0, 0, 1, 1, 32'h4444_3333, 0, 0);
      tbl[5]  = mk(1, 16'h000B, 0, 0, 0, 1, 0, 32'h4444_3333, 0, 0);
      tbl[6]  = mk(1, 16'h000C, 1, 0, 0, 1, 1, 32'h000B_000A, 0, 0);
      tbl[7]  = mk(0, 16'h0000, 0, 0, 0, 1, 1, 32'h0000_000C, 0, 0);
      tbl[8]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 32'h0000_000C, 1, 1);
      tbl[9]  = mk(0, 16'h0000, 0, 0, 0, 1, 0, 32'h0000_000C, 0, 1);
      // full held for 5 cycles with a complete word waiting
      tbl[10] = mk(1, 16'h5555, 0, 1, 0, 1, 0, 32'h0000_000C, 0, 1);
      tbl[11] = mk(1, 16'h6666, 1, 1, 0, 1, 0, 32'h0000_000C, 0, 1);
      tbl[12] = mk(1, 16'h7777, 0, 1, 0, 0, 0, 32'h6666_5555, 0, 1);
      tbl[13] = mk(1, 16'h7777, 0, 1, 0, 0, 0, 32'h6666_5555, 0, 1);
      tbl[14] = mk(1, 16'h7777, 0, 1, 0, 0, 0, 32'h6666_5555, 0, 1);
      tbl[15] = mk(1, 16'h7777, 0, 1, 0, 0, 0, 32'h6666_5555, 0, 1);
      tbl[16] = mk(1, 16'h7777, 0, 1, 0, 0, 0, 32'h6666_5555, 0, 1);
      tbl[17] = mk(1, 16'h7777, 0, 0, 0, 1, 1, 32'h6666_5555, 0, 1);
      tbl[18] = mk(1, 16'h8888, 1, 0, 0, 1, 0, 32'h6666_5555, 1, 2);
      tbl[19] = mk(0, 16'h0000, 0, 0, 0, 1, 1, 32'h8888_7777, 0, 2);
      tbl[20] = mk(0, 16'h0000, 0, 0, 0, 1, 0, 32'h8888_7777, 1, 3);
      tbl[21] = mk(0, 16'h0000, 0, 0, 0, 1, 0, 32'h8888_7777, 0, 3);
      // wr_rst_busy after one pixel: partial dropped, next word starts at lane 0
      tbl[22] = mk(1, 16'h1234, 0, 0, 0, 1, 0, 32'h8888_7777, 0, 3);
      tbl[23] = mk(0, 16'h0000, 0, 0, 1, 1, 0, 32'h8888_7777, 0, 3);
      tbl[24] = mk(0, 16'h0000, 0, 0, 1, 0, 0, 32'h8888_7777, 0, 3);
      tbl[25] = mk(1, 16'hAAAA, 0, 0, 0, 0, 0, 32'h8888_7777, 0, 3);
      tbl[26] = mk(1, 16'hAAAA, 0, 0, 0, 1, 0, 32'h8888_7777, 0, 3);
      tbl[27] = mk(1, 16'hBBBB, 1, 0, 0, 1, 0, 32'h8888_7777, 0, 3);
      tbl[28] = mk(0, 16'h0000, 0, 0, 0, 1, 1, 32'hBBBB_AAAA, 0, 3);
      tbl[29] = mk(0, 16'h0000, 0, 0, 0, 1, 0, 32'hBBBB_AAAA, 1, 4);
      // wr_rst_busy while a complete word is held: word is never written
      tbl[30] = mk(1, 16'hCCCC, 1, 0, 0, 1, 0, 32'hBBBB_AAAA, 0, 4);
      tbl[31] = mk(0, 16'h0000, 0, 0, 1, 0, 0, 32'h0000_CCCC, 0, 4);
      tbl[32] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 32'h0000_CCCC, 0, 4);
      tbl[33] = mk(0, 16'h0000, 0, 0, 0, 1, 0, 32'h0000_CCCC, 0, 4);

      // Reset with the FIFO still busy
      rst_n = 1'b0;
      drive(0, 16'h0, 0, 0, 1);
      #2;
      chk("rst ready",     64'(bus0.s_pix_ready), 64'd0);
      chk("rst wr_en",     64'(bus0.fifo_wr_en),  64'd0);
      chk("rst din",       64'(bus0.fifo_din),    64'd0);
      chk("rst line_done", 64'(line_done0),       64'd0);
      chk("rst line_cnt",  64'(line_cnt0),        64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("busy%0d ready", c), 64'(bus0.s_pix_ready), 64'd0);
         @(posedge clk); #1;
      end
      bus0.fifo_wr_rst_busy = 1'b0;
      @(negedge clk);
      chk("busy drop ready", 64'(bus0.s_pix_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("run ready", 64'(bus0.s_pix_ready), 64'd1);
      @(posedge clk); #1;

      // One row per clock cycle
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].v, tbl[i].pix, tbl[i].eol, tbl[i].full, tbl[i].busy);
         @(negedge clk);
         chk($sformatf("row%0d ready", i),     64'(bus0.s_pix_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("row%0d wr_en", i),     64'(bus0.fifo_wr_en),  64'(tbl[i].e_wr));
         chk($sformatf("row%0d din", i),       64'(bus0.fifo_din),    64'(tbl[i].e_din));
         chk($sformatf("row%0d line_done", i), 64'(line_done0),       64'(tbl[i].e_ld));
         chk($sformatf("row%0d line_cnt", i),  64'(line_cnt0),        64'(tbl[i].e_lc));
         @(posedge clk); #1;
      end

      // Async reset mid-line clears everything at once
      drive(1, 16'h0101, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 16'h0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst ready",    64'(bus0.s_pix_ready), 64'd0);
      chk("midrst wr_en",    64'(bus0.fifo_wr_en),  64'd0);
      chk("midrst din",      64'(bus0.fifo_din),    64'd0);
      chk("midrst line_cnt", 64'(line_cnt0),        64'd0);
      chk("midrst n1 cnt",   64'(line_cnt1),        64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 65537 one-pixel lines at full rate; both DUTs write each pixel one cycle after accepting it
      for (int i = 0; i < 65537; i++) begin
         drive(1, 16'(i), 1, 0, 0);
         prev = (i == 0) ? 16'h0000 : 16'(i - 1);
         @(negedge clk);
         exp_v = {9'd0, 1'b1, (i > 0), (i >= 2), 16'h0000, prev,
                        1'b1, (i > 0), (i >= 2), prev};
         act_v = {9'd0, bus0.s_pix_ready, bus0.fifo_wr_en, line_done0, bus0.fifo_din,
                        bus1.s_pix_ready, bus1.fifo_wr_en, line_done1, bus1.fifo_din};
         chk($sformatf("line%0d", i), act_v, exp_v);
         @(posedge clk); #1;
      end
      drive(0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("last wr_en", 64'({bus0.fifo_wr_en, bus1.fifo_wr_en}), 64'd3);
      chk("last din",   64'({bus0.fifo_din, bus1.fifo_din}),     64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wrap line_cnt",  64'(line_cnt0),  64'd1);
      chk("n1 line_cnt",    64'(line_cnt1),  64'd1);
      chk("wrap line_done", 64'({line_done0, line_done1}), 64'd3);
      chk("idle wr_en",     64'({bus0.fifo_wr_en, bus1.fifo_wr_en}), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done pulse end", 64'({line_done0, line_done1}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
